// File: rtl/operand_fetch_wb_pkg.sv
// Shared types and sizes for the operand fetch / writeback slice.
package operand_fetch_wb_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/operand_fetch_wb_reg_scoreboard.sv
// Pending-write scoreboard: busy bits, hazard detection and stray-writeback flag.
// OPERAND_FETCH_WB_BYPASS_EN lets a same-cycle writeback clear a source hazard.
module reg_scoreboard
    import operand_fetch_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] chk_src1,
    input  logic [REG_ADDR_W-1:0] chk_src2,
    input  logic [REG_ADDR_W-1:0] chk_dest,
    input  logic                  chk_wen,
    output logic                  hazard,
    output logic                  wb_err,
    output logic [NUM_REGS-1:0]   busy
);

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                wb_err_reg;
    logic                src1_busy;
    logic                src2_busy;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
        assign set_vec[gi] = set_en && (set_addr == REG_ADDR_W'(gi));
        assign clr_vec[gi] = clr_en && (clr_addr == REG_ADDR_W'(gi));
    end

    // Set is applied after clear so a new owner of the register wins.
    assign busy_next = (busy_reg & ~clr_vec) | set_vec;

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    // The bank is written at this edge, so READ already sees the new value.
    assign src1_busy = busy_reg[chk_src1] && !(clr_en && (clr_addr == chk_src1));
    assign src2_busy = busy_reg[chk_src2] && !(clr_en && (clr_addr == chk_src2));
`else
    assign src1_busy = busy_reg[chk_src1];
    assign src2_busy = busy_reg[chk_src2];
`endif

    assign hazard = src1_busy || src2_busy || (chk_wen && busy_reg[chk_dest]);
    assign busy   = busy_reg;
    assign wb_err = wb_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg   <= '0;
            wb_err_reg <= 1'b0;
        end else begin
            busy_reg   <= busy_next;
            wb_err_reg <= clr_en && !busy_reg[clr_addr];
        end
    end

endmodule

// File: rtl/operand_fetch_wb.sv
// Operand fetch stage with register-bank read, writeback forwarding and scoreboard.
// Define OPERAND_FETCH_WB_BYPASS_EN to let writebacks bypass the source hazard check.
module operand_fetch_wb
    import operand_fetch_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [REG_ADDR_W-1:0] iss_src1,
    input  logic [REG_ADDR_W-1:0] iss_src2,
    input  logic [REG_ADDR_W-1:0] iss_dest,
    input  logic                  iss_wen,
    output logic [REG_ADDR_W-1:0] rb_srcadd1,
    output logic [REG_ADDR_W-1:0] rb_srcadd2,
    input  logic [DATA_W-1:0]     rb_src1,
    input  logic [DATA_W-1:0]     rb_src2,
    output logic [REG_ADDR_W-1:0] rb_dest,
    output logic [DATA_W-1:0]     rb_din,
    output logic                  rb_we,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_W-1:0]     op_a,
    output logic [DATA_W-1:0]     op_b,
    output logic [REG_ADDR_W-1:0] op_dest,
    output logic                  op_wen,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  wb_err,
    output logic [NUM_REGS-1:0]   busy
);

    state_t                state_reg;
    state_t                state_next;
    logic                  hazard;
    logic                  accept;
    logic [REG_ADDR_W-1:0] srcadd1_reg;
    logic [REG_ADDR_W-1:0] srcadd2_reg;
    logic [REG_ADDR_W-1:0] op_dest_reg;
    logic                  op_wen_reg;
    logic [DATA_W-1:0]     op_a_reg;
    logic [DATA_W-1:0]     op_b_reg;
    logic                  op_valid_reg;

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (accept && iss_wen),
        .set_addr (iss_dest),
        .clr_en   (wb_valid),
        .clr_addr (wb_dest),
        .chk_src1 (iss_src1),
        .chk_src2 (iss_src2),
        .chk_dest (iss_dest),
        .chk_wen  (iss_wen),
        .hazard   (hazard),
        .wb_err   (wb_err),
        .busy     (busy)
    );

    assign iss_ready = (state_reg == IDLE) && !hazard;
    assign accept    = iss_valid && iss_ready;

    // Writebacks go straight to the bank with no buffering.
    assign rb_we   = wb_valid;
    assign rb_dest = wb_dest;
    assign rb_din  = wb_data;

    assign rb_srcadd1 = srcadd1_reg;
    assign rb_srcadd2 = srcadd2_reg;
    assign op_valid   = op_valid_reg;
    assign op_a       = op_a_reg;
    assign op_b       = op_b_reg;
    assign op_dest    = op_dest_reg;
    assign op_wen     = op_wen_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = HOLD;
            HOLD:    if (op_valid_reg && op_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            srcadd1_reg  <= '0;
            srcadd2_reg  <= '0;
            op_dest_reg  <= '0;
            op_wen_reg   <= 1'b0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Only IDLE accepts, so dest/wen never change under a pending op_valid.
            if (accept) begin
                srcadd1_reg <= iss_src1;
                srcadd2_reg <= iss_src2;
                op_dest_reg <= iss_dest;
                op_wen_reg  <= iss_wen;
            end
            if (state_reg == READ) begin
                op_a_reg     <= rb_src1;
                op_b_reg     <= rb_src2;
                op_valid_reg <= 1'b1;
            end else if (state_reg == HOLD && op_ready) begin
                op_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch_wb.sv
// Self-checking bench for operand_fetch_wb with a register bank model and result queue.
`timescale 1ns/1ps
module tb_operand_fetch_wb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iss_valid, iss_ready, iss_wen;
    logic [3:0]  iss_src1, iss_src2, iss_dest;
    logic [3:0]  rb_srcadd1, rb_srcadd2, rb_dest;
    logic [31:0] rb_src1, rb_src2, rb_din;
    logic        rb_we;
    logic        op_valid, op_ready, op_wen;
    logic [31:0] op_a, op_b;
    logic [3:0]  op_dest;
    logic        wb_valid, wb_err;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic [15:0] busy;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  dest;
        logic        wen;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] bank [16];
    logic [15:0] busy_m;
    logic        err_m;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    operand_fetch_wb dut (
        .clk(clk), .reset(reset),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_dest(iss_dest), .iss_wen(iss_wen),
        .rb_srcadd1(rb_srcadd1), .rb_srcadd2(rb_srcadd2),
        .rb_src1(rb_src1), .rb_src2(rb_src2),
        .rb_dest(rb_dest), .rb_din(rb_din), .rb_we(rb_we),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_dest(op_dest), .op_wen(op_wen),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .wb_err(wb_err), .busy(busy)
    );

    // Register bank: combinational read, written by the forwarded writeback.
    assign rb_src1 = bank[rb_srcadd1];
    assign rb_src2 = bank[rb_srcadd2];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) bank[i] <= 32'(i * 17) - 32'd17;
        end else if (rb_we) begin
            bank[rb_dest] <= rb_din;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        iss_valid = 0; iss_src1 = 0; iss_src2 = 0; iss_dest = 0; iss_wen = 0;
        op_ready = 1; wb_valid = 0; wb_dest = 0; wb_data = 0;
    endtask

    function automatic logic [31:0] src_val(input logic [3:0] r);
        // The operands are read in the cycle after acceptance, after any writeback lands.
        return (wb_valid && wb_dest == r) ? wb_data : bank[r];
    endfunction

    // One cycle of observation at the falling edge: scoreboard and busy model.
    task automatic sample();
        logic [15:0] nxt;
        exp_t        e;
        @(negedge clk);
        n_checks++;
        if (busy !== busy_m) begin
            n_fail++; $display("FAIL busy: got %h required %h", busy, busy_m);
        end
        n_checks++;
        if (wb_err !== err_m) begin
            n_fail++; $display("FAIL wb_err: got %b required %b", wb_err, err_m);
        end
        n_checks++;
        if ({rb_we, rb_dest, rb_din} !== {wb_valid, wb_dest, wb_data}) begin
            n_fail++;
            $display("FAIL wb_forward: got we=%b dest=%0d din=%h required we=%b dest=%0d din=%h",
                     rb_we, rb_dest, rb_din, wb_valid, wb_dest, wb_data);
        end
        if (op_valid === 1'b1 && op_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL op_unexpected: got op_valid=1 a=%h required no pending operand", op_a);
            end else begin
                e = exp_q.pop_front();
                if ({op_a, op_b, op_dest, op_wen} !== {e.a, e.b, e.dest, e.wen}) begin
                    n_fail++;
                    $display("FAIL op_data: got a=%h b=%h dest=%0d wen=%b required a=%h b=%h dest=%0d wen=%b",
                             op_a, op_b, op_dest, op_wen, e.a, e.b, e.dest, e.wen);
                end else begin
                    $display("txn op a=%h b=%h dest=%0d wen=%b", op_a, op_b, op_dest, op_wen);
                end
            end
        end
        err_m = wb_valid && !busy_m[wb_dest];
        nxt = busy_m;
        if (wb_valid) nxt[wb_dest] = 1'b0;
        if (iss_valid && iss_ready === 1'b1) begin
            if (iss_wen) nxt[iss_dest] = 1'b1;
            e.a = src_val(iss_src1);
            e.b = src_val(iss_src2);
            e.dest = iss_dest;
            e.wen = iss_wen;
            exp_q.push_back(e);
        end
        busy_m = nxt;
    endtask

    task automatic check_ready(input string name, input logic req);
        n_checks++;
        if (iss_ready !== req) begin
            n_fail++; $display("FAIL %s: got iss_ready=%b required %b", name, iss_ready, req);
        end
    endtask

    task automatic wait_op(input string name);
        bit got = 0;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (op_valid === 1'b1 && op_ready) begin
                got = 1;
                tick();
                break;
            end
            tick();
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL %s_timeout: got no op_valid required op_valid within 6 cycles", name);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if ({busy, op_valid, op_a, op_b, op_dest, op_wen, rb_srcadd1, rb_srcadd2, wb_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%h op_valid=%b a=%h b=%h dest=%0d wen=%b s1=%0d s2=%0d err=%b required all 0",
                     busy, op_valid, op_a, op_b, op_dest, op_wen, rb_srcadd1, rb_srcadd2, wb_err);
        end
        check_ready("reset_ready", 1'b1);
        @(negedge clk);
        reset = 1'b0;
        busy_m = '0; err_m = 1'b0; exp_q.delete();
        tick();
    endtask

    task automatic test_basic();
        iss_valid = 1; iss_src1 = 2; iss_src2 = 3; iss_dest = 5; iss_wen = 1;
        sample();
        check_ready("basic_accept", 1'b1);
        tick();
        iss_valid = 0;
        sample();
        n_checks++;
        if (op_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_early_valid: got %b required 0", op_valid);
        end
        tick();
        sample();
        n_checks++;
        if (op_valid !== 1'b1 || op_a !== 32'h11 || op_b !== 32'h22 || busy[5] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: got valid=%b a=%h b=%h busy5=%b required 1 00000011 00000022 1",
                     op_valid, op_a, op_b, busy[5]);
        end
        tick();
    endtask

    task automatic test_hazard();
        iss_valid = 1; iss_src1 = 5; iss_src2 = 0; iss_dest = 6; iss_wen = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check_ready("hazard_stall", 1'b0);
            tick();
        end
        wb_valid = 1; wb_dest = 5; wb_data = 32'h5555_0005;
        sample();
`ifdef OPERAND_FETCH_WB_BYPASS_EN
        check_ready("hazard_bypass", 1'b1);
        tick();
        wb_valid = 0; iss_valid = 0;
`else
        check_ready("hazard_wb_cycle", 1'b0);
        tick();
        wb_valid = 0;
        sample();
        check_ready("hazard_release", 1'b1);
        tick();
        iss_valid = 0;
`endif
        wait_op("hazard");
    endtask

    task automatic test_backpressure();
        exp_t head;
        op_ready = 0;
        iss_valid = 1; iss_src1 = 4; iss_src2 = 7; iss_dest = 8; iss_wen = 1;
        sample();
        check_ready("bp_accept", 1'b1);
        tick();
        iss_src1 = 1; iss_src2 = 1; iss_dest = 9; iss_wen = 0;
        sample();
        check_ready("bp_read", 1'b0);
        tick();
        head = exp_q[0];
        for (int k = 0; k < 4; k++) begin
            sample();
            n_checks++;
            if (op_valid !== 1'b1 || op_a !== head.a || op_b !== head.b) begin
                n_fail++;
                $display("FAIL bp_stable: got valid=%b a=%h b=%h required 1 %h %h",
                         op_valid, op_a, op_b, head.a, head.b);
            end
            check_ready("bp_hold", 1'b0);
            tick();
        end
        op_ready = 1;
        sample();
        check_ready("bp_handshake", 1'b0);
        tick();
        sample();
        check_ready("bp_idle", 1'b1);
        tick();
        iss_valid = 0;
        wait_op("bp_second");
    endtask

    task automatic test_wb_err();
        wb_valid = 1; wb_dest = 7; wb_data = 32'h0000_0777;
        sample();
        tick();
        wb_valid = 0;
        sample();
        n_checks++;
        if (wb_err !== 1'b1) begin
            n_fail++; $display("FAIL wberr_pulse: got %b required 1", wb_err);
        end
        tick();
        sample();
        n_checks++;
        if (wb_err !== 1'b0) begin
            n_fail++; $display("FAIL wberr_once: got %b required 0", wb_err);
        end
        tick();
        // Clearing a genuinely busy register is not an error.
        wb_valid = 1; wb_dest = 8; wb_data = 32'h0000_0888;
        sample();
        tick();
        wb_valid = 0;
        sample();
        tick();
        // Same-cycle set and clear of r9: the set survives.
        iss_valid = 1; iss_src1 = 0; iss_src2 = 7; iss_dest = 9; iss_wen = 1;
        wb_valid = 1; wb_dest = 9; wb_data = 32'h0000_0999;
        sample();
        check_ready("setclr_accept", 1'b1);
        tick();
        iss_valid = 0; wb_valid = 0;
        sample();
        n_checks++;
        if (busy[9] !== 1'b1) begin
            n_fail++; $display("FAIL set_wins: got busy9=%b required 1", busy[9]);
        end
        tick();
        wait_op("setclr");
        wb_valid = 1; wb_dest = 9; wb_data = 32'h0000_0909;
        sample();
        tick();
        wb_valid = 0;
        sample();
        tick();
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        bit took;
        op_ready = 1;
        iss_valid = 1; iss_src1 = 1; iss_src2 = 2; iss_dest = 3; iss_wen = 0;
        for (int i = 0; i < 9; i++) begin
            sample();
            took = (iss_ready === 1'b1);
            if (took) accepts++;
            tick();
            if (took) begin
                iss_src1 = iss_src1 + 4'd1;
                iss_src2 = iss_src2 + 4'd3;
            end
        end
        iss_valid = 0;
        n_checks++;
        if (accepts != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_rate: got %0d accepts %0d pending required 3 accepts 0 pending",
                     accepts, exp_q.size());
        end
    endtask

    task automatic test_reset_inflight();
        iss_valid = 1; iss_src1 = 2; iss_src2 = 3; iss_dest = 5; iss_wen = 1;
        sample();
        check_ready("rst_accept", 1'b1);
        tick();
        iss_valid = 0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 16'h0 || op_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_inflight: got busy=%h valid=%b required 0000 0", busy, op_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        busy_m = '0; err_m = 1'b0; exp_q.delete();
        tick();
        for (int i = 0; i < 4; i++) begin
            sample();
            n_checks++;
            if (op_valid !== 1'b0) begin
                n_fail++; $display("FAIL rst_no_valid: got %b required 0", op_valid);
            end
            check_ready("rst_ready", 1'b1);
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        busy_m = '0;
        err_m = 1'b0;
        test_reset();
        test_basic();
        test_hazard();
        test_backpressure();
        test_wb_err();
        test_back_to_back();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch_wb.md
OPERAND_FETCH_WB -- requirements
Module: operand_fetch_wb

Interface
REQ-001 The module SHALL have one clock, clk, and one reset, reset, which is asynchronous and active-high.
REQ-002 The ports SHALL be, clock and reset first, one per line as name, direction, width, meaning:
 clk  in  1  rising-edge clock
 reset  in  1  async active-high reset
 iss_valid  in  1  decoded instruction offered
 iss_ready  out  1  instruction accepted this cycle when high with iss_valid
 iss_src1  in  4  first source register
 iss_src2  in  4  second source register
 iss_dest  in  4  destination register
 iss_wen  in  1  instruction will write iss_dest
 rb_srcadd1  out  4  register bank read address 1
 rb_srcadd2  out  4  register bank read address 2
 rb_src1  in  32  register bank read data 1 (combinational from rb_srcadd1)
 rb_src2  in  32  register bank read data 2
 rb_dest  out  4  register bank write address
 rb_din  out  32  register bank write data
 rb_we  out  1  register bank write strobe
 op_valid  out  1  operands available
 op_ready  in  1  consumer accepts operands
 op_a  out  32  operand 1
 op_b  out  32  operand 2
 op_dest  out  4  destination carried with operands
 op_wen  out  1  write flag carried with operands
 wb_valid  in  1  writeback result present (always accepted)
 wb_dest  in  4  writeback register
 wb_data  in  32  writeback value
 wb_err  out  1  one-cycle pulse: writeback to non-busy register
 busy  out  16  scoreboard, bit n = register n has pending write

Function
REQ-003 The FSM SHALL have states IDLE, READ, HOLD.
REQ-004 hazard SHALL be busy[iss_src1] | busy[iss_src2] | (iss_wen & busy[iss_dest]).
REQ-005 iss_ready SHALL be 1 only in IDLE with hazard 0; acceptance = iss_valid & iss_ready.
REQ-006 On acceptance (cycle N), the module SHALL register rb_srcadd1/2, dest and wen, and go to READ.
REQ-007 In READ (cycle N+1), the module SHALL capture rb_src1 -> op_a and rb_src2 -> op_b, assert op_valid from N+2, and go to HOLD.
REQ-008 In HOLD, op_a/op_b/op_dest/op_wen SHALL stay stable while op_valid & !op_ready; on op_valid & op_ready, op_valid SHALL drop next cycle and the state SHALL return to IDLE.
REQ-009 Issue-to-operand latency SHALL be 2 cycles; back-to-back throughput SHALL be one instruction per 3 cycles when op_ready is held high.
REQ-010 On acceptance with iss_wen=1, busy[iss_dest] SHALL be set at the next edge.
REQ-011 rb_we, rb_dest and rb_din SHALL combinationally equal wb_valid, wb_dest and wb_data; every writeback SHALL be forwarded to the bank.
REQ-012 On wb_valid, busy[wb_dest] SHALL clear at the next edge; if busy[wb_dest] was 0, wb_err SHALL pulse for one cycle.
REQ-013 When acceptance sets and writeback clears the same bit in one cycle, the set SHALL win.
REQ-014 The hazard check SHALL use the pre-edge busy value; a writeback in the same cycle as a hazarded issue SHALL still stall that cycle, except as in REQ-018.

Reset
REQ-015 While reset is high, state SHALL be IDLE, busy SHALL be 0, and op_valid, op_a, op_b, op_dest, op_wen, rb_srcadd1, rb_srcadd2 and wb_err SHALL be 0.
REQ-016 Reset asserted during READ or HOLD SHALL discard the in-flight instruction with no op_valid pulse.

Configuration
REQ-017 Macro OPERAND_FETCH_WB_BYPASS_EN SHALL select writeback bypass of the hazard check.
REQ-018 With the macro defined, a source register equal to wb_dest with wb_valid=1 SHALL be treated as not busy in the hazard check; the bank holds the value by the READ cycle.
REQ-019 With the macro undefined, REQ-004 SHALL apply unchanged.

Structure
REQ-020 A shared package SHALL hold the FSM state encoding, REG_ADDR_W=4, DATA_W=32 and NUM_REGS=16.
REQ-021 One sub-module, reg_scoreboard, SHALL hold the busy vector, set/clear logic, hazard computation and wb_err.

Verification
REQ-022 Issue src1=2, src2=3, dest=5, wen=1 at N, with bank r2=0x11 and r3=0x22 -> op_valid at N+2, op_a=0x11, op_b=0x22, op_dest=5, busy[5]=1.
REQ-023 With busy[5]=1, issue src1=5 -> iss_ready=0 until the cycle after wb_valid with wb_dest=5; under BYPASS_EN it is accepted in the wb cycle itself.
REQ-024 Hold op_ready=0 for 4 cycles -> op_a/op_b stable, iss_ready=0 throughout, IDLE one cycle after op_ready=1.
REQ-025 wb_valid with wb_dest=7 while busy=0 -> rb_we=1, rb_dest=7, wb_err pulses once, busy unchanged.
REQ-026 Assert reset in READ with busy[5]=1 -> busy=0, op_valid never rises, iss_ready=1 after release.
